// File: rtl/tinyrv_spi_mem_if.sv
// Core memory-port bundle between tinyrv and the SPI memory initiator.
interface tinyrv_spi_mem_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/tinyrv_spi_mem.sv
// SPI SRAM initiator: one READ(0x03)/WRITE(0x02) transaction per core request,
// SPI mode 0 at clk/2, little-endian byte order on the data phase.
module tinyrv_spi_mem #(
  parameter int unsigned ADDR_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  tinyrv_spi_mem_if.slave bus,
  output logic            spi_cs_n,
  output logic            spi_sck,
  output logic            spi_mosi,
  input  logic            spi_miso
);
  localparam int unsigned HDR_W = 8 + ADDR_W;
  localparam int unsigned TX_W  = HDR_W + 32;
  localparam int unsigned CNT_W = $clog2(TX_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              cs_n_q, cs_n_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  nbits_q, nbits_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              accept;

  // Reverse byte order of the low 1/2/4 bytes, zero-filling the rest.
  function automatic logic [31:0] byte_swap(input logic [31:0] v, input logic [1:0] size);
    case (size)
      2'd0:    return {24'd0, v[7:0]};
      2'd1:    return {16'd0, v[7:0], v[15:8]};
      default: return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] frame_bits(input logic [1:0] size);
    case (size)
      2'd0:    return CNT_W'(HDR_W + 8);
      2'd1:    return CNT_W'(HDR_W + 16);
      default: return CNT_W'(HDR_W + 32);
    endcase
  endfunction

  assign accept = bus.req_valid & ready_q;

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    nbits_d     = nbits_q;
    write_d     = write_q;
    size_d      = size_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          state_d = SHIFT;
          ready_d = 1'b0;
          write_d = bus.req_write;
          size_d  = bus.req_size;
          nbits_d = frame_bits(bus.req_size);
          cnt_d   = '0;
          rx_d    = '0;
          // Frame is left-aligned; only the first nbits_d bits are ever shifted out.
          tx_d    = {bus.req_write ? 8'h02 : 8'h03, bus.req_addr,
                     bus.req_write ? byte_swap(bus.req_wdata, 2'd2) : 32'd0};
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = tx_d[TX_W-1];
        end
      end

      SHIFT: begin
        if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          // Falling sck edge: sample miso during read data, then advance or finish.
          sck_d = 1'b0;
          if (!write_q && cnt_q >= CNT_W'(HDR_W)) begin
            rx_d = {rx_q[30:0], spi_miso};
          end
          if (cnt_q == nbits_q - CNT_W'(1)) begin
            state_d     = DONE;
            cs_n_d      = 1'b1;
            mosi_d      = 1'b0;
            rsp_valid_d = 1'b1;
            if (!write_q) begin
              rdata_d = byte_swap(rx_d, size_q);
            end
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            tx_d   = tx_q << 1;
            mosi_d = tx_d[TX_W-1];
          end
        end
      end

      DONE: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        ready_d     = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      nbits_q     <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      nbits_q     <= nbits_d;
      write_q     <= write_d;
      size_q      <= size_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign spi_cs_n      = cs_n_q;
  assign spi_sck       = sck_q;
  assign spi_mosi      = mosi_q;
endmodule
